// File: rtl/div_pkg.sv
// div_pkg: shared types, constants and helpers for the sequential divider.
// The optional signed mode is selected by the DIV_SIGNED_EN macro in div_seq_core.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } divState_e;

  // Width of the iteration counter; a single-bit operand still needs one counter bit.
  function automatic int cntWidth(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Quotient reported for a zero divisor: all ones at the requested width.
  function automatic logic [63:0] divzero_quotient(input int width);
    logic [63:0] ones;
    ones = '1;
    return ones >> (64 - width);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
// Shifts {partial remainder, shift register} left by one, trial-subtracts the
// divisor at WIDTH+1 bits and keeps the difference when it is non-negative.
// The returned shift register has a zero LSB; the caller merges in qBit_o.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] partRem_i,
  input  logic [WIDTH-1:0] shiftReg_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] partRem_o,
  output logic [WIDTH-1:0] shiftReg_o,
  output logic             qBit_o
);

  logic [WIDTH:0] shiftedRem;
  logic [WIDTH:0] trial;

  // Trial subtraction; a set MSB on the difference means the divisor did not fit.
  always_comb begin
    shiftedRem = {partRem_i, shiftReg_i[WIDTH-1]};
    trial      = shiftedRem - {1'b0, divisor_i};
    qBit_o     = ~trial[WIDTH];
    partRem_o  = qBit_o ? trial[WIDTH-1:0] : shiftedRem[WIDTH-1:0];
    shiftReg_o = shiftReg_i << 1;
  end

endmodule

// File: rtl/div_seq_core.sv
// div_seq_core: iterative radix-2 restoring divider, one quotient bit per cycle.
// Optional macro DIV_SIGNED_EN: two's complement operands with a FIX cycle that
// applies the result signs (latency WIDTH+3 edges instead of WIDTH+2).
module div_seq_core
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CntW = cntWidth(WIDTH);
  localparam logic [CntW-1:0] LastCount = CntW'(WIDTH - 1);

  divState_e        state_q, state_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] partRem_q, partRem_d;
  logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
`ifdef DIV_SIGNED_EN
  logic             quotNeg_q, quotNeg_d;
  logic             remNeg_q, remNeg_d;
`endif

  logic [WIDTH-1:0] stepRem;
  logic [WIDTH-1:0] stepShift;
  logic             stepQBit;
  logic [WIDTH-1:0] stepShiftMerged;

  div_step #(.WIDTH(WIDTH)) uStep (
    .partRem_i  (partRem_q),
    .shiftReg_i (shiftReg_q),
    .divisor_i  (divisor_q),
    .partRem_o  (stepRem),
    .shiftReg_o (stepShift),
    .qBit_o     (stepQBit)
  );

  assign stepShiftMerged = stepShift | WIDTH'(stepQBit);

  // Next-state and datapath control; everything holds while ena is low.
  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    partRem_d   = partRem_q;
    shiftReg_d  = shiftReg_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
`ifdef DIV_SIGNED_EN
    quotNeg_d   = quotNeg_q;
    remNeg_d    = remNeg_q;
`endif
    if (ena) begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            dividend_d = dividend;
            divisor_d  = divisor;
            state_d    = LOAD;
          end
        end
        LOAD: begin
          if (divisor_q == '0) begin
            quotient_d  = WIDTH'(divzero_quotient(WIDTH));
            remainder_d = dividend_q;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
            state_d     = DONE;
          end else begin
            partRem_d = '0;
            count_d   = LastCount;
`ifdef DIV_SIGNED_EN
            shiftReg_d = dividend_q[WIDTH-1] ? -dividend_q : dividend_q;
            divisor_d  = divisor_q[WIDTH-1] ? -divisor_q : divisor_q;
            quotNeg_d  = dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1];
            remNeg_d   = dividend_q[WIDTH-1];
`else
            shiftReg_d = dividend_q;
`endif
            state_d = RUN;
          end
        end
        RUN: begin
          partRem_d  = stepRem;
          shiftReg_d = stepShiftMerged;
          count_d    = count_q - CntW'(1);
          if (count_q == '0) begin
`ifdef DIV_SIGNED_EN
            state_d = FIX;
`else
            quotient_d  = stepShiftMerged;
            remainder_d = stepRem;
            dbz_d       = 1'b0;
            done_d      = 1'b1;
            state_d     = DONE;
`endif
          end
        end
        FIX: begin
`ifdef DIV_SIGNED_EN
          quotient_d  = quotNeg_q ? -shiftReg_q : shiftReg_q;
          remainder_d = remNeg_q ? -partRem_q : partRem_q;
          dbz_d       = 1'b0;
          done_d      = 1'b1;
          state_d     = DONE;
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      partRem_q   <= '0;
      shiftReg_q  <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIV_SIGNED_EN
      quotNeg_q   <= 1'b0;
      remNeg_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      partRem_q   <= partRem_d;
      shiftReg_q  <= shiftReg_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
`ifdef DIV_SIGNED_EN
      quotNeg_q   <= quotNeg_d;
      remNeg_q    <= remNeg_d;
`endif
    end
  end

  // Status and result outputs, decoded from registers only.
  always_comb begin
    busy        = (state_q == LOAD) || (state_q == RUN) || (state_q == FIX);
    done        = done_q;
    quotient    = quotient_q;
    remainder   = remainder_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: doc/div_seq_core.md
Name: div_seq_core

Overview:
- Iterative radix-2 restoring divider core.
- Sits directly downstream of the tt_um_devider pin wrapper. The wrapper maps ui_in to the dividend and uio_in to the divisor, and drives uo_out with the quotient or remainder.
- Accepts one operand pair per start pulse and produces quotient and remainder after a fixed latency.
- Reports status through busy, done and div_by_zero.

Parameters:
- WIDTH, 8: operand, quotient and remainder width in bits.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ena  in  1  design enable; when low, start is ignored and the FSM holds its state.
- start  in  1  operand-valid strobe; sampled only in IDLE or DONE.
- dividend  in  WIDTH  numerator; captured on the accepting edge.
- divisor  in  WIDTH  denominator; captured on the accepting edge.
- busy  out  1  high while an operation is in flight (LOAD, RUN, FIX).
- done  out  1  one-cycle pulse when results become valid.
- quotient  out  WIDTH  result, held until the next accept.
- remainder  out  WIDTH  result, held until the next accept.
- div_by_zero  out  1  high with the results when the captured divisor was 0; held with the results.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state = IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0; internal registers = 0.
- States:
  - IDLE
  - LOAD
  - RUN
  - FIX (present only with the optional feature)
  - DONE
- Accept: in IDLE or DONE with ena = 1 and start = 1, operands are captured and the next state is LOAD. Accept in DONE allows back-to-back operations.
- LOAD:
  - If divisor == 0: quotient = all-ones, remainder = dividend, div_by_zero = 1; go to DONE.
  - Otherwise: partial remainder = 0, shift register = dividend, iteration count = WIDTH-1; go to RUN.
- RUN, one iteration per cycle:
  - shift {partial remainder, shift register} left by 1;
  - trial = partial remainder − divisor, computed WIDTH+1 bits wide;
  - if trial ≥ 0, commit it and set quotient LSB to 1; otherwise restore and set it to 0;
  - after the iteration with count = 0, go to DONE (or to FIX when signed).
- DONE: quotient and remainder registers update on entry. done = 1 for exactly the first cycle in DONE, then the FSM stays in DONE with outputs held.
- Latency: done is high in the cycle following the (WIDTH+2)th rising edge after the accepting edge, i.e. 10 edges for WIDTH = 8. Divide-by-zero latency is 2 edges.
- start while busy is ignored. It is not queued and does not alter operands in flight.
- ena low mid-operation freezes the FSM and the count. The operation resumes when ena returns high.
- rst_n low mid-operation aborts immediately: state returns to IDLE and all outputs go to their reset values.
- busy is combinational from state and glitch-free (decoded from registers only).

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined:
  - Operands are two's complement. Magnitudes are taken in LOAD.
  - FIX state (1 cycle) negates the quotient if the operand signs differ, and negates the remainder if the dividend is negative. Quotient truncates toward zero.
  - Overflow case −2^(WIDTH−1) / −1 gives quotient = 0x80, remainder = 0, with no flag.
  - Divide by zero gives quotient = all-ones, remainder = dividend.
  - Latency is WIDTH+3 edges.
- Undefined: unsigned only, no FIX state, latency WIDTH+2 edges.

Decomposition:
- Package div_pkg holds:
  - state enum (IDLE, LOAD, RUN, FIX, DONE);
  - DIV_WIDTH_DEFAULT = 8;
  - function divzero_quotient returning the all-ones constant for a given width;
  - iteration-counter width $clog2(WIDTH).
- One natural sub-module: div_step, the combinational single restoring iteration. It takes {partial remainder, shift register} and the divisor, and returns the next pair plus the quotient bit.

Test Plan:
- Basic divide: dividend = 100, divisor = 7, start pulse → done exactly 10 edges later; quotient = 14, remainder = 2; busy high for the 9 cycles before done.
- Divide by zero: dividend = 0x5A, divisor = 0 → done after 2 edges; quotient = 0xFF, remainder = 0x5A, div_by_zero = 1.
- Back-to-back and ignored start:
  - start held high from the done cycle with 255/16 → second result quotient = 15, remainder = 15;
  - a start pulse while busy is ignored.
- Stall and abort:
  - ena dropped for 3 cycles mid-RUN with 200/3 → done 13 edges after accept; quotient = 66, remainder = 2.
  - A separate run with rst_n pulsed mid-RUN → outputs 0, state IDLE.
- Signed, with DIV_SIGNED_EN:
  - −100/7 → quotient = −14 (0xF2), remainder = −2 (0xFE);
  - −128/−1 → quotient = 0x80, remainder = 0;
  - latency 11 edges.
- Exhaustive sweep: all 65536 8-bit unsigned operand pairs checked against a reference model (divisor = 0 uses the defined result).
